// File: rtl/decode_pkg.sv
// Shared decode-stage definitions: format bit positions, functional unit IDs,
// register access encodings, common widths and a one-hot check helper.
package decode_pkg;

    // Widths shared by the format decoders
    localparam int ADDRESS_WIDTH      = 64;
    localparam int INSTRUCTION_WIDTH  = 32;
    localparam int PID_SIZE           = 20;
    localparam int TID_SIZE           = 16;
    localparam int INST_COUNTER_WIDTH = 64;
    localparam int OPCODE_SIZE        = 6;
    localparam int FORMAT_COUNT       = 26;
    localparam int REG_ADDR_WIDTH     = 5;

    // Bit positions inside the one-hot format vector (index 0 is the leftmost bit)
    localparam int A_FORMAT   = 0;
    localparam int B_FORMAT   = 1;
    localparam int D_FORMAT   = 2;
    localparam int DQ_FORMAT  = 3;
    localparam int DS_FORMAT  = 4;
    localparam int DX_FORMAT  = 5;
    localparam int I_FORMAT   = 6;
    localparam int M_FORMAT   = 7;
    localparam int MD_FORMAT  = 8;
    localparam int MDS_FORMAT = 9;
    localparam int SC_FORMAT  = 10;
    localparam int VA_FORMAT  = 11;
    localparam int VC_FORMAT  = 12;
    localparam int VX_FORMAT  = 13;
    localparam int X_FORMAT   = 14;
    localparam int XFL_FORMAT = 15;
    localparam int XFX_FORMAT = 16;
    localparam int XL_FORMAT  = 17;
    localparam int XO_FORMAT  = 18;
    localparam int XS_FORMAT  = 19;
    localparam int XX2_FORMAT = 20;
    localparam int XX3_FORMAT = 21;
    localparam int XX4_FORMAT = 22;
    localparam int Z22_FORMAT = 23;
    localparam int Z23_FORMAT = 24;
    localparam int XX1_FORMAT = 25;

    // Functional unit that executes a decoded instruction
    typedef enum logic [2:0] {
        FXUnitId      = 3'd0,
        FPUnitId      = 3'd1,
        VectorUnitId  = 3'd2,
        LdStUnitId    = 3'd3,
        CRUnitId      = 3'd4,
        BranchUnitID  = 3'd5
    } unit_id_e;

    // How a decoded operand touches its register
    typedef enum logic [1:0] {
        REG_NONE       = 2'b00,
        REG_READ       = 2'b01,
        REG_WRITE      = 2'b10,
        REG_READ_WRITE = 2'b11
    } reg_access_e;

    // True when exactly one bit of the (zero-extended) vector is set
    function automatic logic is_one_hot(input logic [63:0] v);
        return (v != 64'd0) && ((v & (v - 64'd1)) == 64'd0);
    endfunction

endpackage

// File: rtl/decode_skid_fifo.sv
// Small synchronous FIFO buffering fetched instructions ahead of issue.
// The head entry is presented combinationally on data_o while not empty.
module decode_skid_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == {CNT_W{1'b0}});
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // Occupancy update: a simultaneous push and pop leaves the count unchanged
    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; depth is a power of two so pointers wrap naturally
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

    // Entry storage; contents need no reset because the count gates visibility
    always_ff @(posedge clock_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/decode_format_dispatcher.sv
// Decode front-end: buffers fetched instructions, tags each with a major ID
// in push order and issues one per cycle to the decoder named by its one-hot
// format. Malformed format vectors are flagged instead of issued.
module decode_format_dispatcher
    import decode_pkg::*;
#(
    parameter int addressWidth            = 64,
    parameter int instructionWidth        = 32,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int instructionCounterWidth = 64,
    parameter int opcodeSize              = 6,
    parameter int formatCount             = 26,
    parameter int fifoDepth               = 2
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               enable_i,
    input  logic [instructionWidth-1:0]        instruction_i,
    input  logic [addressWidth-1:0]            instructionAddress_i,
    input  logic [0:formatCount-1]             instFormat_i,
    input  logic                               is64Bit_i,
    input  logic [PidSize-1:0]                 instructionPid_i,
    input  logic [TidSize-1:0]                 instructionTid_i,
    input  logic                               stall_i,
    output logic                               stall_o,
    output logic [0:formatCount-1]             decoderEnable_o,
    output logic [0:formatCount-1]             instFormat_o,
    output logic [opcodeSize-1:0]              instructionOpcode_o,
    output logic [instructionWidth-1:0]        instruction_o,
    output logic [addressWidth-1:0]            instructionAddress_o,
    output logic                               is64Bit_o,
    output logic [PidSize-1:0]                 instPid_o,
    output logic [TidSize-1:0]                 instTid_o,
    output logic [instructionCounterWidth-1:0] instMajId_o,
    output logic                               invalidFormat_o
);

    localparam int ENTRY_W = instructionWidth + addressWidth + formatCount + 1 + PidSize + TidSize;
    localparam logic [instructionCounterWidth-1:0] MAJ_ONE = {{(instructionCounterWidth-1){1'b0}}, 1'b1};

    logic [ENTRY_W-1:0]          fifo_din_s;
    logic [ENTRY_W-1:0]          fifo_dout_s;
    logic                        fifo_full_s;
    logic                        fifo_empty_s;
    logic                        fifo_push_s;
    logic                        fifo_pop_s;

    logic [instructionWidth-1:0] head_instr_s;
    logic [addressWidth-1:0]     head_addr_s;
    logic [0:formatCount-1]      head_fmt_s;
    logic                        head_is64_s;
    logic [PidSize-1:0]          head_pid_s;
    logic [TidSize-1:0]          head_tid_s;
    logic                        head_fmt_ok_s;

    logic [0:formatCount-1]               decoderEnable_q, decoderEnable_d;
    logic [0:formatCount-1]               instFormat_q,    instFormat_d;
    logic [instructionWidth-1:0]          instruction_q,   instruction_d;
    logic [addressWidth-1:0]              address_q,       address_d;
    logic                                 is64Bit_q,       is64Bit_d;
    logic [PidSize-1:0]                   pid_q,           pid_d;
    logic [TidSize-1:0]                   tid_q,           tid_d;
    logic [instructionCounterWidth-1:0]   majId_q,         majId_d;
    logic                                 invalidFormat_q, invalidFormat_d;
    logic [instructionCounterWidth-1:0]   majIdCounter_q,  majIdCounter_d;

    // Fetch is ignored while the buffer is full; issue only when downstream accepts
    assign fifo_push_s = enable_i && !fifo_full_s;
    assign fifo_pop_s  = !stall_i && !fifo_empty_s;
    assign fifo_din_s  = {instruction_i, instructionAddress_i, instFormat_i,
                          is64Bit_i, instructionPid_i, instructionTid_i};
    assign {head_instr_s, head_addr_s, head_fmt_s,
            head_is64_s, head_pid_s, head_tid_s} = fifo_dout_s;

    // Format vector widths up to 64 are supported by the one-hot helper
    assign head_fmt_ok_s = is_one_hot(64'(head_fmt_s));

    decode_skid_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (fifoDepth)
    ) u_fifo (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .push_i  (fifo_push_s),
        .pop_i   (fifo_pop_s),
        .data_i  (fifo_din_s),
        .data_o  (fifo_dout_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Issue decision: load the head on a pop, clear enables when idle, hold under stall
    always_comb begin
        decoderEnable_d = decoderEnable_q;
        instFormat_d    = instFormat_q;
        instruction_d   = instruction_q;
        address_d       = address_q;
        is64Bit_d       = is64Bit_q;
        pid_d           = pid_q;
        tid_d           = tid_q;
        majId_d         = majId_q;
        invalidFormat_d = invalidFormat_q;
        majIdCounter_d  = majIdCounter_q;
        if (!stall_i) begin
            if (!fifo_empty_s) begin
                // Malformed formats still take an ID so exception order is preserved
                decoderEnable_d = head_fmt_ok_s ? head_fmt_s : {formatCount{1'b0}};
                invalidFormat_d = !head_fmt_ok_s;
                instFormat_d    = head_fmt_s;
                instruction_d   = head_instr_s;
                address_d       = head_addr_s;
                is64Bit_d       = head_is64_s;
                pid_d           = head_pid_s;
                tid_d           = head_tid_s;
                majId_d         = majIdCounter_q;
                majIdCounter_d  = majIdCounter_q + MAJ_ONE;
            end else begin
                decoderEnable_d = {formatCount{1'b0}};
                invalidFormat_d = 1'b0;
            end
        end else begin
            decoderEnable_d = decoderEnable_q;
            invalidFormat_d = invalidFormat_q;
        end
    end

    // Output and ID counter registers; reset clears everything including the counter
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            decoderEnable_q <= {formatCount{1'b0}};
            instFormat_q    <= {formatCount{1'b0}};
            instruction_q   <= {instructionWidth{1'b0}};
            address_q       <= {addressWidth{1'b0}};
            is64Bit_q       <= 1'b0;
            pid_q           <= {PidSize{1'b0}};
            tid_q           <= {TidSize{1'b0}};
            majId_q         <= {instructionCounterWidth{1'b0}};
            invalidFormat_q <= 1'b0;
            majIdCounter_q  <= {instructionCounterWidth{1'b0}};
        end else begin
            decoderEnable_q <= decoderEnable_d;
            instFormat_q    <= instFormat_d;
            instruction_q   <= instruction_d;
            address_q       <= address_d;
            is64Bit_q       <= is64Bit_d;
            pid_q           <= pid_d;
            tid_q           <= tid_d;
            majId_q         <= majId_d;
            invalidFormat_q <= invalidFormat_d;
            majIdCounter_q  <= majIdCounter_d;
        end
    end

    // POWER numbers instruction bits from the MSB, so bits 0..5 are the top six
    assign instructionOpcode_o  = instruction_q[instructionWidth-1 -: opcodeSize];
    assign stall_o              = fifo_full_s;
    assign decoderEnable_o      = decoderEnable_q;
    assign instFormat_o         = instFormat_q;
    assign instruction_o        = instruction_q;
    assign instructionAddress_o = address_q;
    assign is64Bit_o            = is64Bit_q;
    assign instPid_o            = pid_q;
    assign instTid_o            = tid_q;
    assign instMajId_o          = majId_q;
    assign invalidFormat_o      = invalidFormat_q;

endmodule

// File: tb/tb_decode_format_dispatcher.sv
// Self-checking bench for decode_format_dispatcher: a vector table of
// instructions with hand-written expected enables, a queue scoreboard of
// pushed entries, and short sequences for stall, wrap and reset corners.
module tb_decode_format_dispatcher;

    localparam int FC = 26;

    logic          clock_i = 1'b0;
    logic          reset_i;
    logic          enable_i;
    logic [31:0]   instruction_i;
    logic [63:0]   instructionAddress_i;
    logic [0:FC-1] instFormat_i;
    logic          is64Bit_i;
    logic [19:0]   instructionPid_i;
    logic [15:0]   instructionTid_i;
    logic          stall_i;
    logic          stall_o;
    logic [0:FC-1] decoderEnable_o;
    logic [0:FC-1] instFormat_o;
    logic [5:0]    instructionOpcode_o;
    logic [31:0]   instruction_o;
    logic [63:0]   instructionAddress_o;
    logic          is64Bit_o;
    logic [19:0]   instPid_o;
    logic [15:0]   instTid_o;
    logic [63:0]   instMajId_o;
    logic          invalidFormat_o;

    decode_format_dispatcher dut (
        .clock_i              (clock_i),
        .reset_i              (reset_i),
        .enable_i             (enable_i),
        .instruction_i        (instruction_i),
        .instructionAddress_i (instructionAddress_i),
        .instFormat_i         (instFormat_i),
        .is64Bit_i            (is64Bit_i),
        .instructionPid_i     (instructionPid_i),
        .instructionTid_i     (instructionTid_i),
        .stall_i              (stall_i),
        .stall_o              (stall_o),
        .decoderEnable_o      (decoderEnable_o),
        .instFormat_o         (instFormat_o),
        .instructionOpcode_o  (instructionOpcode_o),
        .instruction_o        (instruction_o),
        .instructionAddress_o (instructionAddress_o),
        .is64Bit_o            (is64Bit_o),
        .instPid_o            (instPid_o),
        .instTid_o            (instTid_o),
        .instMajId_o          (instMajId_o),
        .invalidFormat_o      (invalidFormat_o)
    );

    always #5 clock_i = ~clock_i;

    typedef struct packed {
        logic [31:0]   instr;
        logic [63:0]   addr;
        logic [0:FC-1] fmt;
        logic          is64;
        logic [19:0]   pid;
        logic [15:0]   tid;
        logic [0:FC-1] exp_den;
        logic          exp_inv;
    } vec_t;

    typedef struct packed {
        vec_t        v;
        logic [63:0] id;
    } sb_t;

    vec_t        vecs [8];
    sb_t         sb [$];
    sb_t         exp_out;
    logic [63:0] next_id;
    int          checks   = 0;
    int          failures = 0;

    function automatic logic [0:FC-1] fbit(input int i);
        logic [0:FC-1] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    function automatic vec_t mkv(input logic [31:0] instr, input logic [63:0] addr,
                                 input logic [0:FC-1] fmt, input logic is64,
                                 input logic [19:0] pid, input logic [15:0] tid,
                                 input logic [0:FC-1] den, input logic inv);
        vec_t v;
        v.instr = instr; v.addr = addr; v.fmt = fmt; v.is64 = is64;
        v.pid = pid; v.tid = tid; v.exp_den = den; v.exp_inv = inv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic cmp_outputs();
        chk("decoderEnable", 64'(decoderEnable_o), 64'(exp_out.v.exp_den));
        chk("invalidFormat", 64'(invalidFormat_o), 64'(exp_out.v.exp_inv));
        chk("instFormat",    64'(instFormat_o),    64'(exp_out.v.fmt));
        chk("instruction",   64'(instruction_o),   64'(exp_out.v.instr));
        chk("opcode",        64'(instructionOpcode_o), 64'(exp_out.v.instr[31:26]));
        chk("address",       instructionAddress_o, exp_out.v.addr);
        chk("is64Bit",       64'(is64Bit_o),       64'(exp_out.v.is64));
        chk("pid",           64'(instPid_o),       64'(exp_out.v.pid));
        chk("tid",           64'(instTid_o),       64'(exp_out.v.tid));
        chk("majId",         instMajId_o,          exp_out.id);
    endtask

    // One clock: drive at negedge, predict, compare 1 time unit after posedge
    task automatic cycle(input logic en, input vec_t v, input logic st, output logic acc);
        logic exp_stall;
        logic pop;
        sb_t  e;
        enable_i             = en;
        instruction_i        = v.instr;
        instructionAddress_i = v.addr;
        instFormat_i         = v.fmt;
        is64Bit_i            = v.is64;
        instructionPid_i     = v.pid;
        instructionTid_i     = v.tid;
        stall_i              = st;
        exp_stall = (sb.size() == 2);
        chk("stall_o", 64'(stall_o), 64'(exp_stall));
        acc = en && !exp_stall;
        pop = !st && (sb.size() > 0);
        @(posedge clock_i);
        #1;
        if (pop) begin
            e = sb.pop_front();
            exp_out = e;
        end else if (!st) begin
            exp_out.v.exp_den = '0;
            exp_out.v.exp_inv = 1'b0;
        end
        if (acc) begin
            e.v  = v;
            e.id = next_id;
            sb.push_back(e);
            next_id = next_id + 64'd1;
        end
        cmp_outputs();
        @(negedge clock_i);
    endtask

    task automatic do_reset(input logic en, input vec_t v);
        reset_i  = 1'b1;
        enable_i = en;
        instruction_i = v.instr; instructionAddress_i = v.addr; instFormat_i = v.fmt;
        stall_i  = 1'b1;
        @(posedge clock_i);
        #1;
        sb.delete();
        exp_out = '0;
        next_id = 64'd0;
        cmp_outputs();
        chk("reset_stall_o", 64'(stall_o), 64'd0);
        @(negedge clock_i);
        reset_i  = 1'b0;
        enable_i = 1'b0;
        stall_i  = 1'b0;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle(1'b0, vecs[0], 1'b0, acc);
    endtask

    initial begin
        logic acc;
        int   k;
        int   stall_seen;

        vecs[0] = mkv(32'h7C00_0214, 64'h1000, fbit(1), 1'b1, 20'h00011, 16'h0001, fbit(1), 1'b0);
        vecs[1] = mkv(32'h3860_0001, 64'h1004, fbit(0), 1'b0, 20'h00022, 16'h0002, fbit(0), 1'b0);
        vecs[2] = mkv(32'h4800_0010, 64'h1008, '0,      1'b1, 20'h00033, 16'h0003, '0,      1'b1);
        vecs[3] = mkv(32'hE800_0008, 64'h100C, fbit(0) | fbit(3), 1'b0, 20'h00044, 16'h0004, '0, 1'b1);
        vecs[4] = mkv(32'h8061_0004, 64'h1010, fbit(2), 1'b1, 20'h00055, 16'h0005, fbit(2), 1'b0);
        vecs[5] = mkv(32'hF000_0490, 64'h1014, fbit(25), 1'b0, 20'hFFFFF, 16'hFFFF, fbit(25), 1'b0);
        vecs[6] = mkv(32'h1000_0001, 64'hFFFF_FFFF_FFFF_FFFC, fbit(24) | fbit(25), 1'b1, 20'h00066, 16'h0006, '0, 1'b1);
        vecs[7] = mkv(32'h4C00_0020, 64'h1018, fbit(13), 1'b1, 20'h00077, 16'h0007, fbit(13), 1'b0);

        reset_i = 1'b1; enable_i = 1'b0; stall_i = 1'b0;
        instruction_i = '0; instructionAddress_i = '0; instFormat_i = '0;
        is64Bit_i = 1'b0; instructionPid_i = '0; instructionTid_i = '0;
        exp_out = '0; next_id = 64'd0;
        @(negedge clock_i);

        // Reset state, then a single B-format push at 0x1000
        do_reset(1'b0, vecs[0]);
        cycle(1'b1, vecs[0], 1'b0, acc);
        idle(2);

        // Back-to-back stream through the whole table: one issue per cycle, never full
        do_reset(1'b0, vecs[0]);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, vecs[i], 1'b0, acc);
            chk("stream_accept", 64'(acc), 64'd1);
        end
        idle(2);

        // Backpressure: 5-cycle downstream stall in a continuous stream
        do_reset(1'b0, vecs[0]);
        k = 0;
        stall_seen = 0;
        for (int c = 0; c < 16; c++) begin
            if (stall_o) stall_seen++;
            cycle(1'b1, vecs[k % 8], (c >= 3 && c < 8), acc);
            if (acc) k++;
        end
        chk("bp_stall_seen", 64'(stall_seen > 0), 64'd1);
        idle(3);

        // Invalid formats consume IDs 0 and 1; the next valid one gets 2
        do_reset(1'b0, vecs[0]);
        cycle(1'b1, vecs[2], 1'b0, acc);
        cycle(1'b1, vecs[3], 1'b0, acc);
        cycle(1'b1, vecs[4], 1'b0, acc);
        idle(2);
        chk("inv_next_id", next_id, 64'd3);

        // Major ID wrap from all-ones back to zero
        do_reset(1'b0, vecs[0]);
        force dut.majIdCounter_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.majIdCounter_q;
        next_id = 64'hFFFF_FFFF_FFFF_FFFF;
        cycle(1'b1, vecs[7], 1'b0, acc);
        cycle(1'b1, vecs[1], 1'b0, acc);
        idle(2);

        // Reset while full and stalled, with fetch still presenting an entry
        do_reset(1'b0, vecs[0]);
        cycle(1'b1, vecs[0], 1'b0, acc);
        cycle(1'b1, vecs[1], 1'b1, acc);
        cycle(1'b1, vecs[4], 1'b1, acc);
        cycle(1'b1, vecs[5], 1'b1, acc);
        chk("full_before_reset", 64'(stall_o), 64'd1);
        do_reset(1'b1, vecs[5]);
        cycle(1'b1, vecs[7], 1'b0, acc);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_format_dispatcher.md
# decode_format_dispatcher

Decode-stage front-end controller between fetch and the per-format decoders (A, B, D, … format decoders). It buffers fetched instructions in a 2-entry FIFO and assigns each a monotonically increasing major ID. Each cycle it issues one instruction to the single format decoder selected by the one-hot format vector, and it back-pressures fetch when the buffer is full. Instructions with malformed format vectors are flagged rather than issued.

## Interface
Parameters:
- addressWidth, 64, instruction address width
- instructionWidth, 32, fixed 4-byte POWER instruction
- PidSize, 20, process ID width
- TidSize, 16, thread ID width
- instructionCounterWidth, 64, major ID width
- opcodeSize, 6, primary opcode width
- formatCount, 26, number of format decoders (one-hot vector width)
- fifoDepth, 2, buffer entries (power of two)

Ports (one clock; reset is synchronous and active-high):
- clock_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- enable_i  in  1  fetch presents a valid instruction
- instruction_i  in  instructionWidth  raw instruction
- instructionAddress_i  in  addressWidth  instruction address
- instFormat_i  in  [0:formatCount-1]  one-hot format from format pre-decode
- is64Bit_i  in  1  64-bit mode
- instructionPid_i  in  PidSize  process ID
- instructionTid_i  in  TidSize  thread ID
- stall_i  in  1  downstream decoders cannot accept
- stall_o  out  1  FIFO full; fetch must hold
- decoderEnable_o  out  [0:formatCount-1]  one-hot enable to format decoders
- instFormat_o  out  [0:formatCount-1]  format vector of the issued instruction
- instructionOpcode_o  out  opcodeSize  instruction bits [0:5]
- instruction_o, instructionAddress_o, is64Bit_o, instPid_o, instTid_o  out  as inputs  issued instruction fields
- instMajId_o  out  instructionCounterWidth  major ID of the issued instruction
- invalidFormat_o  out  1  issued instruction had zero or multiple format bits set

## Operation
- Push: at the clock edge, push when enable_i && !stall_o. The stored entry holds the instruction, address, format, is64Bit, PID and TID.
- Fetch holds its inputs while stall_o is high, and inputs are ignored during that time.
- stall_o = (count == fifoDepth). It is decoded from the registered count, with no combinational path from any input.
- Pop/issue: at an edge with !stall_i, one of two things happens:
  - FIFO non-empty: the head is loaded into the output registers.
  - FIFO empty: decoderEnable_o and invalidFormat_o are cleared, and the other outputs hold.
- On a pop:
  - instMajId_o is loaded with the internal majIdCounter, and the counter increments.
  - The counter wraps from 2^64-1 to 0.
- Format check on the head:
  - Exactly one bit set: decoderEnable_o = instFormat, invalidFormat_o = 0.
  - Zero bits or more than one bit set: decoderEnable_o = 0, invalidFormat_o = 1.
  - Invalid instructions still consume a major ID, which keeps exception ordering intact.
- Stall hold: while stall_i is high, all output registers hold, including decoderEnable_o. Decoders gate on stall_i themselves.
- Simultaneous push and pop: count is unchanged and both pointers advance. This is legal even when count is 1.
- Push and pop are never simultaneous when full, because stall_o blocks the push.
- Reset:
  - FIFO is emptied (pointers and count to 0) and majIdCounter is set to 0.
  - Every output is set to 0, including stall_o = 0.
  - An entry in flight is discarded.
  - The first post-reset issue carries major ID 0.

## Timing
- Latency: an instruction pushed at edge N is issued at edge N+1 at the earliest (outputs valid during cycle N+1). There is no bypass.
- Throughput: 1 instruction per cycle sustained with stall_i low and enable_i high. The FIFO never fills in this case.
- Backpressure: stall_i asserted for k cycles with continuous fetch gives stall_o = 1 from the second cycle after the stall begins. It deasserts one cycle after stall_i drops.
- Major IDs appear on instMajId_o strictly in push order, with no gaps, invalid formats included.

## Structure
- Shared package decode_pkg holds:
  - format bit index constants (A_FORMAT = 0, B_FORMAT = 1, …)
  - functional unit IDs (FXUnitId … BranchUnitID)
  - the regRead/regWrite encodings
  - the width constants used by all format decoders
- Sub-module decode_skid_fifo: a parameterized width × fifoDepth synchronous FIFO.
  - Ports: push, pop, data in, data out, full, empty, reset_i.
  - The dispatcher instantiates it with the concatenated entry fields and adds the ID counter, format check and output registers.

## Test plan
- Reset then single push: B-format instruction (format bit 1) at address 0x1000 → one cycle later decoderEnable_o = bit 1 only, instMajId_o = 0, instructionAddress_o = 0x1000, invalidFormat_o = 0.
- Back-to-back stream: 8 instructions over 8 cycles, stall_i = 0 → IDs 0..7 issued on consecutive cycles, stall_o never asserts.
- Backpressure: stall_i = 1 for 5 cycles during a continuous stream → stall_o asserts once 2 entries are buffered, outputs hold, no instruction is lost or duplicated, IDs stay contiguous after release.
- Invalid formats: format = 0, then format with bits 0 and 3 set → invalidFormat_o = 1 and decoderEnable_o = 0 for both, IDs consumed (0, 1), next valid instruction gets ID 2.
- Wrap: preload majIdCounter to 2^64-1 via forced state → issue yields 0xFFFF_FFFF_FFFF_FFFF then 0.
- Reset mid-operation: FIFO full with stall_i = 1, assert reset_i for one cycle → all outputs 0, stall_o = 0, next issued instruction carries ID 0.
